// File: rtl/fifo_ptr_ctrl.sv
// Head/tail pointer controller for a power-of-two circular FIFO.
// Produces storage write strobe/addresses and occupancy status flags.
module fifo_ptr_ctrl #(
    parameter int unsigned DEPTH_LOG2   = 3,
    parameter int unsigned AFULL_THRESH = (2 ** DEPTH_LOG2) - 1
) (
    input  logic                  clk,
    input  logic                  rst_aL,
    input  logic                  flush,
    input  logic                  enq_valid,
    output logic                  enq_ready,
    input  logic                  deq_ready,
    output logic                  deq_valid,
    output logic                  wr_en,
    output logic [DEPTH_LOG2-1:0] wr_addr,
    output logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full
);

    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic             enq_fire;
    logic             deq_fire;

    // Status derived purely from the registered pointers; MSB is the wrap bit.
    always_comb begin
        empty       = (head_q == tail_q);
        full        = (head_q[DEPTH_LOG2-1:0] == tail_q[DEPTH_LOG2-1:0]) &&
                      (head_q[DEPTH_LOG2] != tail_q[DEPTH_LOG2]);
        count       = tail_q - head_q;
        almost_full = (32'(count) >= AFULL_THRESH);
        enq_ready   = !full;
        deq_valid   = !empty;
        enq_fire    = enq_valid && enq_ready;
        deq_fire    = deq_valid && deq_ready;
        wr_en       = enq_fire;
        wr_addr     = tail_q[DEPTH_LOG2-1:0];
        rd_addr     = head_q[DEPTH_LOG2-1:0];
    end

    // Flush outranks both fires; the natural carry out of the index bits toggles the wrap bit.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (enq_fire) tail_d = tail_q + PTR_W'(1);
            if (deq_fire) head_d = head_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed bench for fifo_ptr_ctrl: a counter-based occupancy model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_fifo_ptr_ctrl;

    localparam int unsigned DL    = 3;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AFT   = 7;

    logic          clk;
    logic          rst_aL;
    logic          flush;
    logic          enq_valid;
    logic          enq_ready;
    logic          deq_ready;
    logic          deq_valid;
    logic          wr_en;
    logic [DL-1:0] wr_addr;
    logic [DL-1:0] rd_addr;
    logic [DL:0]   count;
    logic          full;
    logic          empty;
    logic          almost_full;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: total entries ever enqueued / dequeued since the last clear.
    int m_enq = 0;
    int m_deq = 0;

    fifo_ptr_ctrl #(.DEPTH_LOG2(DL), .AFULL_THRESH(AFT)) dut (
        .clk         (clk),
        .rst_aL      (rst_aL),
        .flush       (flush),
        .enq_valid   (enq_valid),
        .enq_ready   (enq_ready),
        .deq_ready   (deq_ready),
        .deq_valid   (deq_valid),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .rd_addr     (rd_addr),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_aL) begin
        int occ;
        if (!rst_aL) begin
            m_enq = 0;
            m_deq = 0;
        end else if (flush) begin
            m_enq = 0;
            m_deq = 0;
        end else begin
            occ = m_enq - m_deq;
            if (enq_valid && occ < int'(DEPTH)) m_enq++;
            if (deq_ready && occ > 0) m_deq++;
        end
    end

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        int occ;
        occ = m_enq - m_deq;
        chk("count",       int'(count),       occ);
        chk("empty",       int'(empty),       int'(occ == 0));
        chk("full",        int'(full),        int'(occ == int'(DEPTH)));
        chk("almost_full", int'(almost_full), int'(occ >= int'(AFT)));
        chk("enq_ready",   int'(enq_ready),   int'(occ != int'(DEPTH)));
        chk("deq_valid",   int'(deq_valid),   int'(occ != 0));
        chk("wr_en",       int'(wr_en),       int'(enq_valid && occ < int'(DEPTH)));
        chk("wr_addr",     int'(wr_addr),     m_enq % int'(DEPTH));
        chk("rd_addr",     int'(rd_addr),     m_deq % int'(DEPTH));
    end

    task automatic step(input logic ev, input logic dr, input logic fl);
        @(posedge clk);
        #1;
        enq_valid = ev;
        deq_ready = dr;
        flush     = fl;
    endtask

    initial begin
        rst_aL    = 1'b0;
        flush     = 1'b0;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        #3;
        chk("rst_count",     int'(count),     0);
        chk("rst_empty",     int'(empty),     1);
        chk("rst_enq_ready", int'(enq_ready), 1);
        chk("rst_deq_valid", int'(deq_valid), 0);
        @(posedge clk);
        #1;
        rst_aL = 1'b1;

        // Fill to full.
        repeat (8) step(1'b1, 1'b0, 1'b0);
        chk("fill_count7", int'(count),       7);
        chk("fill_af7",    int'(almost_full), 1);
        chk("fill_full7",  int'(full),        0);
        step(1'b0, 1'b0, 1'b0);
        chk("fill_count8", int'(count),     8);
        chk("fill_full8",  int'(full),      1);
        chk("fill_ready8", int'(enq_ready), 0);
        chk("fill_wraddr", int'(wr_addr),   0);

        // Drain to empty; head has now wrapped once.
        repeat (8) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("drain_empty",  int'(empty),   1);
        chk("drain_count",  int'(count),   0);
        chk("drain_rdaddr", int'(rd_addr), 0);

        // Interleaved one-by-one traffic across the wrap.
        repeat (12) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0);
        chk("ilv_wraddr", int'(wr_addr), 4);
        chk("ilv_count",  int'(count),   0);

        // Steady state at count 4 with both sides firing.
        repeat (4) step(1'b1, 1'b0, 1'b0);
        repeat (10) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("ss_count",  int'(count),   4);
        chk("ss_wraddr", int'(wr_addr), 2);
        chk("ss_rdaddr", int'(rd_addr), 6);

        // Full with both valid and ready: only dequeue fires.
        repeat (4) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        #1;
        chk("full_both_wren", int'(wr_en), 0);
        chk("full_both_cnt8", int'(count), 8);
        step(1'b0, 1'b0, 1'b0);
        chk("full_both_cnt7", int'(count), 7);

        // Flush at count 5 overrides a concurrent enqueue.
        repeat (2) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        #1;
        chk("flush_wren",  int'(wr_en), 1);
        chk("flush_cnt5",  int'(count), 5);
        step(1'b0, 1'b0, 1'b0);
        chk("flush_count", int'(count),   0);
        chk("flush_empty", int'(empty),   1);
        chk("flush_wr",    int'(wr_addr), 0);
        chk("flush_rd",    int'(rd_addr), 0);

        // Asynchronous reset pulse mid-stream.
        repeat (5) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("pre_arst_cnt", int'(count), 5);
        #2;
        rst_aL = 1'b0;
        #1;
        chk("arst_count", int'(count),   0);
        chk("arst_empty", int'(empty),   1);
        chk("arst_wr",    int'(wr_addr), 0);
        step(1'b0, 1'b0, 1'b0);
        rst_aL = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("post_arst_cnt", int'(count),   1);
        chk("post_arst_rd",  int'(rd_addr), 0);
        chk("post_arst_wr",  int'(wr_addr), 1);

        step(1'b0, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_ptr_ctrl.md
FIFO_PTR_CTRL -- requirements
Module: fifo_ptr_ctrl

Interface
REQ-001 Parameter: DEPTH_LOG2, default 3, log2 of entry count; DEPTH = 2**DEPTH_LOG2.
REQ-002 Parameter: AFULL_THRESH, default DEPTH-1, occupancy at or above which almost_full asserts.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_aL  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  synchronous clear of all entries.
REQ-006 enq_valid  input  1  producer offers an entry this cycle.
REQ-007 enq_ready  output  1  controller can accept an entry this cycle.
REQ-008 deq_ready  input  1  consumer takes the head entry this cycle.
REQ-009 deq_valid  output  1  head entry is valid.
REQ-010 wr_en  output  1  write strobe to the storage array; equals the enqueue fire.
REQ-011 wr_addr  output  DEPTH_LOG2  storage index for the enqueue (tail index bits).
REQ-012 rd_addr  output  DEPTH_LOG2  storage index of the head entry (head index bits).
REQ-013 count  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
REQ-014 full, empty, almost_full  output  1 each  occupancy status flags.

Function
REQ-015 Head and tail pointers SHALL each be DEPTH_LOG2+1 bits: low DEPTH_LOG2 bits index, MSB wrap bit; each is a register with write enable plus an increment-by-one adder.
REQ-016 enq_fire = enq_valid & enq_ready; deq_fire = deq_valid & deq_ready; both purely combinational.
REQ-017 enq_ready SHALL equal !full and deq_valid SHALL equal !empty; neither depends on enq_valid or deq_ready.
REQ-018 On enq_fire, tail SHALL increment by 1 modulo 2*DEPTH at the next edge; on deq_fire, head likewise.
REQ-019 Pointer wrap: index bits go DEPTH-1 -> 0 and the wrap bit toggles; no other carry effect.
REQ-020 empty SHALL assert when head == tail (all bits).
REQ-021 full SHALL assert when index bits are equal and wrap bits differ.
REQ-022 count SHALL equal (tail - head) modulo 2*DEPTH, combinational from the registered pointers.
REQ-023 almost_full SHALL assert when count >= AFULL_THRESH.
REQ-024 Simultaneous enq_fire and deq_fire SHALL advance both pointers; count unchanged.
REQ-025 When full, enq_valid SHALL be ignored (no fire), and a concurrent deq_fire still proceeds.
REQ-026 When empty, no bypass: an entry enqueued in cycle N is first visible via deq_valid in cycle N+1.
REQ-027 wr_addr and rd_addr SHALL be the tail and head index bits directly; latency from enq_fire to rd_addr pointing at that entry equals its queue position.
REQ-028 flush SHALL set head and tail to 0 at the next edge and override any enq_fire/deq_fire in the same cycle; wr_en still reflects enq_fire combinationally in that cycle.
REQ-029 Underflow/overflow SHALL be impossible by construction; pointers never move without the corresponding fire.

Reset
REQ-030 While rst_aL is low, head and tail SHALL be 0 immediately, independent of clk.
REQ-031 During and after reset: empty=1, full=0, almost_full=0 (for AFULL_THRESH>0), count=0, enq_ready=1, deq_valid=0, wr_addr=0, rd_addr=0.
REQ-032 Reset asserted mid-operation SHALL discard all entries; first edge after release behaves as from empty.

Verification (DEPTH_LOG2=3, AFULL_THRESH=7)
REQ-033 Reset release, enq_valid=1 for 8 cycles, deq_ready=0 -> wr_addr 0..7, count 1..8, almost_full at count 7, full=1 and enq_ready=0 after 8th fire.
REQ-034 From full, deq_ready=1 for 8 cycles -> rd_addr 0..7, empty=1 and count=0 after last fire; head wrap bit = 1.
REQ-035 Wrap: 12 enq and 12 deq interleaved one-by-one -> wr_addr sequence 0..7,0..3; count alternates 1/0; never full.
REQ-036 Count=4, enq_valid=1 and deq_ready=1 for 10 cycles -> count stays 4, both pointers advance 10 (index 2, wrap toggled once past start).
REQ-037 Full with enq_valid=1 and deq_ready=1 -> only deq fires, count 8 -> 7, wr_en=0 that cycle.
REQ-038 Count=5, flush=1 with enq_valid=1 -> next cycle count=0, empty=1, head=tail=0; rst_aL pulse mid-stream gives same result asynchronously.
